// File: rtl/wb_commit_tracer_pkg.sv
// rtl/wb_commit_tracer_pkg.sv - MEM/WB register layout and commit record types
package wb_commit_tracer_pkg;

  localparam int          COMMIT_SEQ_W = 16;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef struct packed {
    logic [31:0] Pc_Four;
    logic [31:0] Curr_Instr;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
    logic [31:0] Imm_Out;
    logic [31:0] Rs2_Data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
  } mem_wb_reg;

  typedef struct packed {
    logic [COMMIT_SEQ_W-1:0] seq;
    logic [31:0]             pc;
    logic [31:0]             instr;
    logic [4:0]              rd;
    logic                    we;
    logic [31:0]             wdata;
  } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - synchronous FIFO whose head entry sits in an output register
module commit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    remain;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign do_pop      = pop && valid;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign do_push     = push && (!full || do_pop);
  assign rd_ptr_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;
  assign remain      = count - CW'(do_pop);
  assign count_next  = remain + CW'(do_push);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      // Nothing left behind the head: the incoming entry goes straight to the output.
      if (remain == '0) begin
        if (do_push) begin
          dout <= din;
        end
      end else begin
        dout <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/wb_commit_tracer.sv
// rtl/wb_commit_tracer.sv - rebuilds retiring instructions from MEM/WB and queues commit records
module wb_commit_tracer
  import wb_commit_tracer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  mem_wb_reg              wb_in,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output commit_rec_t            trc_rec,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [SEQ_W-1:0]       drop_cnt
);

  commit_rec_t      rec;
  logic [SEQ_W-1:0] seq_q;
  logic             capture;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_wb_bits;

  assign unused_wb_bits = ^wb_in.Rs2_Data;

  assign capture = en && (wb_in.Curr_Instr != BUBBLE_INSTR);
  assign pop     = trc_ready && !fifo_empty;
  assign drop    = capture && fifo_full && !pop;

  always_comb begin
    rec       = '0;
    rec.seq   = COMMIT_SEQ_W'(seq_q);
    rec.pc    = wb_in.Pc_Four - 32'd4;
    rec.instr = wb_in.Curr_Instr;
    rec.rd    = wb_in.rd;
    rec.we    = wb_in.RegWrite && (wb_in.rd != 5'd0);
    if (rec.we) begin
      case (wb_in.MemtoReg)
        WB_SEL_ALU: rec.wdata = wb_in.Alu_Result;
        WB_SEL_MEM: rec.wdata = wb_in.MemReadData;
        WB_SEL_PC4: rec.wdata = wb_in.Pc_Four;
        default:    rec.wdata = wb_in.Imm_Out;
      endcase
    end
  end

  commit_fifo #(
    .WIDTH($bits(commit_rec_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (capture),
    .din  (rec),
    .pop  (pop),
    .dout (trc_rec),
    .valid(trc_valid),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(count)
  );

  // seq advances on dropped captures too, so gaps downstream reveal lost records.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (capture) begin
        seq_q <= seq_q + SEQ_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + SEQ_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_tracer.sv
// tb/tb_wb_commit_tracer.sv - scoreboard bench for wb_commit_tracer
module tb_wb_commit_tracer;
  import wb_commit_tracer_pkg::*;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             trc_ready;
  logic             trc_valid;
  logic             overflow;
  mem_wb_reg        wb_in;
  commit_rec_t      trc_rec;
  logic [CW-1:0]    count;
  logic [SEQ_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_commit_tracer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .wb_in    (wb_in),
    .trc_valid(trc_valid),
    .trc_ready(trc_ready),
    .trc_rec  (trc_rec),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  commit_rec_t exp_q[$];
  int          occ     = 0;
  int          m_seq   = 0;
  int          m_drops = 0;
  bit          m_ovf   = 0;
  int          chk_occ   = 0;
  int          chk_drops = 0;
  bit          chk_ovf   = 0;
  bit          mon_on    = 0;
  bit          hold_prev = 0;
  commit_rec_t prev_rec;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic commit_rec_t expect_rec(input mem_wb_reg w, input int seq);
    commit_rec_t r;
    logic [31:0] srcs [4];
    srcs    = '{w.Alu_Result, w.MemReadData, w.Pc_Four, w.Imm_Out};
    r.seq   = 16'(seq);
    r.pc    = w.Pc_Four - 32'd4;
    r.instr = w.Curr_Instr;
    r.rd    = w.rd;
    r.we    = w.RegWrite && (w.rd != 5'd0);
    r.wdata = r.we ? srcs[w.MemtoReg] : 32'h0;
    return r;
  endfunction

  // Drive one clock of stimulus and advance the reference model across that edge.
  task automatic cycle(input logic rst, input logic e, input logic rdy, input mem_wb_reg w);
    bit pop, cap, was_full;
    chk_occ   = occ;
    chk_ovf   = m_ovf;
    chk_drops = m_drops;
    reset     = rst;
    en        = e;
    trc_ready = rdy;
    wb_in     = w;
    if (rst) begin
      occ = 0; m_seq = 0; m_drops = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      pop      = (occ > 0) && rdy;
      cap      = e && (w.Curr_Instr != 32'h0);
      was_full = (occ == DEPTH);
      if (pop) occ--;
      if (cap) begin
        if (was_full && !pop) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end else begin
          exp_q.push_back(expect_rec(w, m_seq));
          occ++;
        end
        m_seq = (m_seq + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic mem_wb_reg rand_wb(input int bubble_pct);
    mem_wb_reg w;
    w.Pc_Four     = $urandom();
    w.Curr_Instr  = ($urandom_range(99) < bubble_pct) ? 32'h0 : ($urandom() | 32'h1);
    w.Alu_Result  = $urandom();
    w.MemReadData = $urandom();
    w.Imm_Out     = $urandom();
    w.Rs2_Data    = $urandom();
    w.rd          = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
    w.RegWrite    = 1'($urandom_range(1));
    w.MemtoReg    = 2'($urandom_range(3));
    return w;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      check("count", count, chk_occ);
      check("trc_valid", trc_valid, chk_occ != 0);
      check("overflow", overflow, chk_ovf);
      check("drop_cnt", drop_cnt, chk_drops);
      if (hold_prev) check("rec_hold", trc_rec, prev_rec);
      hold_prev = trc_valid && !trc_ready && !reset;
      prev_rec  = trc_rec;
      if (trc_valid && trc_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rec", trc_rec, 128'hx);
        end else begin
          check("rec", trc_rec, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    mem_wb_reg w0, w;
    w0 = '0;
    cycle(1'b1, 1'b0, 1'b0, w0);
    mon_on = 1;
    cycle(1'b1, 1'b0, 1'b0, w0);
    check("reset_count", count, 0);
    check("reset_valid", trc_valid, 0);

    w = '0;
    w.Pc_Four = 32'h0000_0108; w.Curr_Instr = 32'h0020_81B3; w.RegWrite = 1'b1;
    w.rd = 5'd3; w.MemtoReg = WB_SEL_ALU; w.Alu_Result = 32'h7;
    cycle(1'b0, 1'b1, 1'b1, w);
    check("alu_valid", trc_valid, 1);
    check("alu_pc", trc_rec.pc, 32'h104);
    check("alu_rd_we", {trc_rec.rd, trc_rec.we}, {5'd3, 1'b1});
    check("alu_wdata", trc_rec.wdata, 32'h7);
    check("alu_seq", trc_rec.seq, 0);

    repeat (3) cycle(1'b0, 1'b1, 1'b1, w0);
    check("bubble_valid", trc_valid, 0);

    w = '0;
    w.Pc_Four = 32'h10; w.Curr_Instr = 32'h0000_0013; w.RegWrite = 1'b1;
    w.rd = 5'd0; w.Alu_Result = 32'h5;
    cycle(1'b0, 1'b1, 1'b1, w);
    check("x0_we_wdata", {trc_rec.we, trc_rec.wdata}, 33'h0);
    check("x0_seq", trc_rec.seq, 1);

    w = '0;
    w.Pc_Four = 32'h14; w.Curr_Instr = 32'h0000_A283; w.RegWrite = 1'b1;
    w.rd = 5'd5; w.MemtoReg = WB_SEL_MEM; w.MemReadData = 32'hDEAD_BEEF;
    cycle(1'b0, 1'b1, 1'b1, w);
    check("load_wdata", trc_rec.wdata, 32'hDEAD_BEEF);

    w = '0;
    w.Pc_Four = 32'h20; w.Curr_Instr = 32'h0080_00EF; w.RegWrite = 1'b1;
    w.rd = 5'd1; w.MemtoReg = WB_SEL_PC4;
    cycle(1'b0, 1'b1, 1'b1, w);
    check("jal_wdata", trc_rec.wdata, 32'h20);
    check("jal_pc", trc_rec.pc, 32'h1C);

    w = '0;
    w.Pc_Four = 32'h0; w.Curr_Instr = 32'h0000_0013;
    cycle(1'b0, 1'b1, 1'b1, w);
    check("pc_wrap", trc_rec.pc, 32'hFFFF_FFFC);
    repeat (2) cycle(1'b0, 1'b1, 1'b1, w0);

    cycle(1'b1, 1'b0, 1'b0, w0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, rand_wb(0));
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_cnt, 2);
    check("ovf_head_seq", trc_rec.seq, 0);
    cycle(1'b0, 1'b1, 1'b1, rand_wb(0));
    check("fullpop_count", count, 8);
    check("fullpop_drops", drop_cnt, 2);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'($urandom_range(1)), w0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1, w0);

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, rand_wb(0));
    check("pre_reset_count", count, 5);
    cycle(1'b1, 1'b0, 1'b0, w0);
    check("midreset_count", count, 0);
    check("midreset_valid", trc_valid, 0);
    check("midreset_ovf_drops", {overflow, drop_cnt}, 17'h0);
    cycle(1'b0, 1'b1, 1'b0, rand_wb(0));
    check("post_reset_seq", trc_rec.seq, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) cycle(1'b1, 1'b0, 1'b0, w0);
      else cycle(1'b0, 1'($urandom_range(9) < 8), 1'($urandom_range(1)), rand_wb(20));
    end
    repeat (DEPTH + 4) cycle(1'b0, 1'b0, 1'b1, w0);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_tracer.md
Name: wb_commit_tracer

Overview:
- Sits on the write-back side of the 5-stage RISC-V pipeline.
- Reads the MEM/WB pipeline register every cycle, rebuilds the architectural effect of each retiring instruction (PC, instruction, destination register, write-back value), and queues it as a commit record.
- A downstream consumer (testbench scoreboard or debug UART) drains the queue through a valid/ready handshake.
- It is the consumer end of the pipeline-register interface: stages write the registers, this block reads and retires them.

Parameters:
- DEPTH, 8, commit FIFO entries; power of two, minimum 2
- SEQ_W, 16, width of the commit sequence number and of the drop counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  tracing enable; 0 suppresses capture, draining continues
- wb_in  input  200  MEM/WB register contents (mem_wb_reg struct from the pipeline package)
- trc_valid  output  1  head record available
- trc_ready  input  1  consumer accepts head record
- trc_rec  output  118  head commit record (commit_rec_t)
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky; set on first dropped record
- drop_cnt  output  SEQ_W  number of dropped records, saturating

Behaviour:
- Reset: one clock and one reset only. Synchronous, active-high; "reset" is sampled on the rising edge of "clk". It clears the FIFO pointers, count=0, trc_valid=0, trc_rec=0, overflow=0, drop_cnt=0 and seq=0. Reset mid-stream discards all queued records with no partial output.
- Capture condition (push): en=1 and wb_in.Curr_Instr != 32'h0000_0000. Zero instructions are the flush/bubble encoding and are never recorded.
- Record build, combinational from wb_in:
  - pc = Pc_Four - 4, modulo 2^32 (Pc_Four=0 gives pc=32'hFFFF_FFFC)
  - instr = Curr_Instr
  - rd = rd
  - we = RegWrite && (rd != 0)
  - wdata = 0 when we=0. Otherwise selected by MemtoReg: 2'b00 Alu_Result, 2'b01 MemReadData, 2'b10 Pc_Four, 2'b11 Imm_Out.
  - seq = current sequence counter
- Sequence counter: increments on every capture-condition cycle, including dropped ones, so gaps in seq expose drops. It wraps at 2^SEQ_W.
- Pop: trc_valid && trc_ready.
- Output register: trc_rec and trc_valid are registered.
  - A record captured at edge N into an empty FIFO is presented at trc_valid after edge N. The bypass latency is 1 cycle.
  - trc_rec is held stable while trc_valid && !trc_ready.
- Full: a push when count==DEPTH and no pop in the same cycle drops the record, sets overflow, and increments drop_cnt (saturating at all-ones).
- Push and pop in the same cycle:
  - at full, the push is accepted with no drop and count is unchanged;
  - at empty, pop is impossible (trc_valid=0), so the push proceeds normally.
- Pointers: read and write pointers wrap modulo DEPTH. count is never greater than DEPTH and never below 0.
- en deasserted: no pushes and seq frozen. Queued records still drain.

Decomposition:
- Pipeline package gains:
  - the commit_rec_t packed struct {seq[SEQ_W-1:0], pc[31:0], instr[31:0], rd[4:0], we, wdata[31:0]}
  - a localparam for the bubble encoding 32'h0
  - the MemtoReg select constants
- One sub-module, commit_fifo: a generic synchronous FIFO with a registered output, parameterised by width and depth, with push/pop/full/empty/count.
- The top level handles record building, drop accounting and sequence numbering.

Test Plan:
- ALU write: Pc_Four=32'h0000_0108, Curr_Instr=32'h0020_81B3 (add x3,x1,x2), RegWrite=1, rd=3, MemtoReg=00, Alu_Result=32'h0000_0007, trc_ready=1 -> one cycle later trc_valid=1 with pc=0x104, rd=3, we=1, wdata=7, seq=0.
- Bubble and x0 handling:
  - Curr_Instr=0 for 3 cycles -> no records.
  - Then a record with rd=0, RegWrite=1 -> we=0, wdata=0.
- Write-back select: a load with MemtoReg=01, MemReadData=32'hDEAD_BEEF gives wdata=DEADBEEF; a jal with MemtoReg=10, Pc_Four=0x20 gives wdata=0x20.
- Backpressure and overflow:
  - trc_ready=0, DEPTH=8, push 10 records -> count=8, overflow=1, drop_cnt=2.
  - Release trc_ready -> records drain with seq 0..7 in order and trc_rec stable while stalled.
- Full with simultaneous pop: hold the FIFO full, assert trc_ready and push in the same cycle -> no drop, count stays 8, drop_cnt unchanged.
- Reset mid-stream: 5 records queued, assert reset 1 cycle -> count=0, trc_valid=0, overflow=0, drop_cnt=0; the next push carries seq=0.
